// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
// The state enum is deliberately 1 bit wide: there are only two states.
package rf_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int REG_ZERO = 0;
    localparam int NUM_REGS = 32;
    localparam int LAST_REG = NUM_REGS - 1;

    // Highest register index for a given index width.
    function automatic int lastIndex(input int addrW);
        return (1 << addrW) - 1;
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_arb.sv
// Two-way round-robin grant, purely combinational.
// The parent owns the "last granted" flop; last=1 means requester 1 won most recently.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            // On contention, hand the port to whoever did not win last time.
            if (&valid) grant = last ? 2'b01 : 2'b10;
            else        grant = valid;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the register file: zero-fills regs 1..N-1 after reset or
// init_req, then arbitrates two writeback requesters onto one registered write port.
module regfile_wb_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              init_done,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(lastIndex(ADDR_W));
    localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(REG_ZERO);

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic              last;
    logic [1:0]        grant;
    logic              arbEn;
    logic              handshake;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    // init_req blocks acceptance in the same cycle so no write slips past a restart.
    assign arbEn = (state == ST_RUN) && !init_req;

    rr_arbiter2 uArb (
        .valid ({req1_valid, req0_valid}),
        .last  (last),
        .en    (arbEn),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign handshake  = |grant;
    assign selAddr    = grant[1] ? req1_addr : req0_addr;
    assign selData    = grant[1] ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            ptr       <= FIRST_PTR;
            last      <= 1'b1;
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            init_done <= 1'b0;
            wr_count  <= '0;
        end else if (state == ST_INIT) begin
            regWrite  <= 1'b1;
            writeReg  <= ptr;
            writeData <= '0;
            ptr       <= ptr + FIRST_PTR;
            if (ptr == LAST_PTR) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end else if (init_req) begin
            state     <= ST_INIT;
            ptr       <= FIRST_PTR;
            init_done <= 1'b0;
            regWrite  <= 1'b0;
        end else if (handshake) begin
            // r0 writes complete the handshake but never reach the file or the count.
            writeReg  <= selAddr;
            writeData <= selData;
            last      <= grant[1];
            regWrite  <= (selAddr != ZERO_IDX);
            if (selAddr != ZERO_IDX) wr_count <= wr_count + CNT_W'(1);
        end else begin
            regWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed + randomized bench for regfile_wb_ctrl with a behavioural register file
// downstream and a reference model built from the handshake/arbitration rules.
module tb_regfile_wb_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_req = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          r0, r1;
    logic          regWrite;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic          init_done;
    logic [CW-1:0] wr_count;

    regfile_wb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_req   (init_req),
        .req0_valid (v0),
        .req0_addr  (a0),
        .req0_data  (d0),
        .req0_ready (r0),
        .req1_valid (v1),
        .req1_addr  (a1),
        .req1_data  (d1),
        .req1_ready (r1),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .init_done  (init_done),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    // Downstream register file: no reset, starts with junk so zero-fill is visible.
    logic [DW-1:0] rf [32] = '{default: 32'hBAD0BAD0};
    always @(posedge clk) if (regWrite && writeReg != 0) rf[writeReg] <= writeData;

    function automatic logic [DW-1:0] rd(input int i);
        return (i == 0) ? '0 : rf[i];
    endfunction

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] expRf [32];
    bit            mLast;      // 1: requester 1 was granted most recently
    int            mCnt;
    logic [AW-1:0] mReg;
    logic [DW-1:0] mData;
    bit            g0, g1;     // model grants of the last cycle
    logic          obsR0, obsR1;
    logic [DW-1:0] saved;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One RUN-state cycle: inputs are already driven at the negedge.
    task automatic cyc();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            hs;
        #1;
        g0 = 0; g1 = 0;
        if (!init_req) begin
            if (v0 && v1) begin g0 = mLast; g1 = !mLast; end
            else          begin g0 = v0;    g1 = v1;     end
        end
        obsR0 = r0; obsR1 = r1;
        chk("ready0", r0, g0);
        chk("ready1", r1, g1);
        hs = g0 | g1;
        a  = g0 ? a0 : a1;
        d  = g0 ? d0 : d1;
        if (hs) mLast = g1;
        @(posedge clk); @(negedge clk);
        if (hs) begin
            mReg = a; mData = d;
            if (a != 0) begin mCnt++; expRf[a] = d; end
        end
        chk("regWrite", regWrite, hs && a != 0);
        chk("writeReg", writeReg, mReg);
        chk("writeData", writeData, mData);
        chk("wr_count", wr_count, CW'(mCnt));
        chk("init_done", init_done, !init_req);
    endtask

    // Zero-fill: 31 consecutive writes of 0 to regs 1..31, no grants meanwhile.
    task automatic zf();
        for (int k = 1; k <= 31; k++) begin
            #1;
            chk("zf_ready0", r0, 0);
            chk("zf_ready1", r1, 0);
            @(posedge clk); @(negedge clk);
            chk("zf_regWrite", regWrite, 1);
            chk("zf_writeReg", writeReg, k);
            chk("zf_writeData", writeData, 0);
            chk("zf_init_done", init_done, k == 31);
            chk("zf_wr_count", wr_count, CW'(mCnt));
        end
        mReg = 31; mData = '0;
        for (int i = 0; i < 32; i++) expRf[i] = '0;
    endtask

    task automatic checkRf(input string tag);
        for (int i = 0; i < 32; i++) chk(tag, rd(i), expRf[i]);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) expRf[i] = '0;
        mLast = 1; mCnt = 0; mReg = '0; mData = '0;

        // Reset state, with requests present to show ready is held low.
        v0 = 1; v1 = 1;
        #12;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_writeReg", writeReg, 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_ready0", r0, 0);
        chk("rst_ready1", r1, 0);
        v0 = 0; v1 = 0;
        @(negedge clk); rst_n = 1;
        zf();
        cyc();
        checkRf("zerofill_rf");

        // Single write from req0.
        a0 = 5; d0 = 32'hDEADBEEF; v0 = 1;
        cyc();
        v0 = 0;
        cyc();
        chk("t2_r5", rd(5), 32'hDEADBEEF);
        chk("t2_count", wr_count, 1);

        // Write to r0 is accepted and dropped.
        a1 = 0; d1 = 32'hFFFFFFFF; v1 = 1;
        cyc();
        chk("t4_ready1", obsR1, 1);
        v1 = 0;
        cyc();
        chk("t4_r0", rd(0), 0);
        chk("t4_count", wr_count, 1);

        // Contention on the same register: strict alternation, last grant wins.
        v0 = 1; a0 = 3; d0 = 32'hA0A0A0A0;
        v1 = 1; a1 = 3; d1 = 32'hB1B1B1B1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t3_order", obsR1, i % 2);
            if (g1) d1 = d1 + 1;
        end
        v0 = 0; v1 = 0;
        cyc();
        chk("t3_r3", rd(3), 32'hB1B1B1B2);
        chk("t3_count", wr_count, 5);

        // Reset lands between the handshake edge and the file-write edge.
        a1 = 9; d1 = 32'h55AA55AA; v1 = 1;
        saved = expRf[9];
        cyc();
        v1 = 0;
        rst_n = 0;
        #1;
        chk("t5_regWrite_async", regWrite, 0);
        chk("t5_init_done", init_done, 0);
        chk("t5_count", wr_count, 0);
        @(posedge clk); @(negedge clk);
        chk("t5_r9_lost", rd(9), saved);
        mLast = 1; mCnt = 0; mReg = '0; mData = '0;
        rst_n = 1;
        zf();

        // Randomized traffic with occasional restarts; requests hold until accepted.
        g0 = 1; g1 = 1;
        for (int n = 0; n < 300; n++) begin
            if (!v0 || g0) begin
                v0 = ($urandom_range(0, 3) != 0);
                a0 = AW'($urandom_range(0, 31));
                d0 = $urandom;
            end
            if (!v1 || g1) begin
                v1 = ($urandom_range(0, 3) != 0);
                a1 = AW'($urandom_range(0, 31));
                d1 = $urandom;
            end
            init_req = ($urandom_range(0, 63) == 0);
            cyc();
            if (init_req) begin
                init_req = 0;
                zf();
            end
        end
        v0 = 0; v1 = 0;
        cyc();
        checkRf("random_rf");

        // init_req with a pending request: request waits out the zero-fill.
        a0 = 7; d0 = 32'h1; v0 = 1; init_req = 1;
        cyc();
        chk("t6_blocked", obsR0, 0);
        init_req = 0;
        zf();
        cyc();
        chk("t6_accept", obsR0, 1);
        v0 = 0;
        cyc();
        chk("t6_r7", rd(7), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
